// File: rtl/sample_fifo.sv
// ADC sample averager feeding a first-word-fall-through FIFO with sticky overflow.
// Latency: averaged word visible at out_data right after the edge of the window's last strobe.
// Backpressure: out_ready stalls the head; a push into a full FIFO without a pop is dropped.

module sample_fifo_store #(
    parameter int W          = 12,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_vld,
    input  logic [W-1:0]          push_dat,
    input  logic                  pop_rdy,
    output logic                  head_vld,
    output logic [W-1:0]          head_dat,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  drop
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = DEPTH[DEPTH_LOG2:0];

    logic [W-1:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic                    full;
    logic                    do_pop;
    logic                    do_push;

    assign full     = (level == FULL_LVL);
    assign head_vld = (level != '0);
    assign head_dat = head_vld ? mem[rd_ptr] : '0;

    // When full, wr_ptr == rd_ptr, so a concurrent pop frees exactly the slot being written.
    assign do_pop  = head_vld && pop_rdy;
    assign do_push = push_vld && (!full || do_pop);
    assign drop    = push_vld && full && !do_pop;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

module sample_fifo #(
    parameter int WIDTH      = 12,
    parameter int DEPTH_LOG2 = 4,
    parameter int AVG_LOG2   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  clear_ovf
);
    logic              win_vld;
    logic [WIDTH-1:0]  win_dat;
    logic              drop;

    if (AVG_LOG2 == 0) begin : g_pass
        assign win_vld = in_valid;
        assign win_dat = in_data;
    end else begin : g_avg
        localparam int ACC_W = WIDTH + AVG_LOG2;

        // Holds at most 2^AVG_LOG2-1 samples, so acc + in_data always fits ACC_W bits.
        logic [ACC_W-1:0]    acc;
        logic [ACC_W-1:0]    sum;
        logic [AVG_LOG2-1:0] cnt;
        logic                last;

        assign sum     = acc + ACC_W'(in_data);
        assign last    = (cnt == '1);
        assign win_vld = in_valid && last;
        assign win_dat = WIDTH'(sum >> AVG_LOG2);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc <= '0;
                cnt <= '0;
            end else if (in_valid) begin
                cnt <= cnt + 1'b1;
                acc <= last ? '0 : sum;
            end
        end
    end

    sample_fifo_store #(
        .W          (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_store (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (win_vld),
        .push_dat (win_dat),
        .pop_rdy  (out_ready),
        .head_vld (out_valid),
        .head_dat (out_data),
        .level    (level),
        .drop     (drop)
    );

    // A drop in the same cycle as clear_ovf keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sample_fifo.sv
// Directed bench for sample_fifo: averaging, truncation, overflow, full+pop, reset, backpressure.
module tb_sample_fifo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic [11:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  level;
    logic        overflow;
    logic        clear_ovf = 1'b0;

    logic [11:0] pt_out_data;
    logic        pt_out_valid;
    logic        pt_out_ready = 1'b0;
    logic [4:0]  pt_level;
    logic        pt_overflow;

    int n_checks = 0;
    int n_errors = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    sample_fifo u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .clear_ovf (clear_ovf)
    );

    sample_fifo #(.WIDTH(12), .DEPTH_LOG2(4), .AVG_LOG2(0)) u_pt (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (pt_out_data),
        .out_valid (pt_out_valid),
        .out_ready (pt_out_ready),
        .level     (pt_level),
        .overflow  (pt_overflow),
        .clear_ovf (clear_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sample(input logic [11:0] d, input logic pop, input logic clr);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = pop;
        clear_ovf = clr;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clear_ovf = 1'b0;
    endtask

    task automatic push_window(input logic [11:0] v, input logic pop_last, input logic clr_last);
        for (int k = 0; k < 3; k++) send_sample(v, 1'b0, 1'b0);
        send_sample(v, pop_last, clr_last);
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            chk("drain_vld", out_valid, 1);
            chk("drain_dat", out_data, exp_q.pop_front());
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    initial begin
        logic [11:0] vv;
        logic [11:0] held;
        logic        stalled;
        int sent;
        int sub;
        int got;

        // Reset state
        repeat (3) tick();
        chk("rst_level", level, 0);
        chk("rst_vld", out_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_dat", out_data, 0);
        // Inputs are ignored while reset is held
        send_sample(12'd55, 1'b1, 1'b0);
        chk("rst_ignore_in", level, 0);
        rst_n = 1'b1;
        tick();

        // 100..103 -> 406>>2 = 101
        send_sample(12'd100, 1'b0, 1'b0);
        send_sample(12'd101, 1'b0, 1'b0);
        send_sample(12'd102, 1'b0, 1'b0);
        chk("avg_partial_vld", out_valid, 0);
        send_sample(12'd103, 1'b0, 1'b0);
        chk("avg_vld", out_valid, 1);
        chk("avg_dat", out_data, 101);
        chk("avg_level", level, 1);
        chk("pt_level", pt_level, 4);
        chk("pt_head", pt_out_data, 100);

        // Idle cycles with junk on in_data change nothing
        in_data = 12'd777;
        repeat (5) tick();
        chk("idle_level", level, 1);
        chk("idle_dat", out_data, 101);

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pop_level", level, 0);
        chk("pop_vld", out_valid, 0);

        push_window(12'hFFF, 1'b0, 1'b0);
        chk("fullscale_dat", out_data, 12'hFFF);
        exp_q.push_back(12'hFFF);
        drain(1);
        send_sample(12'd0, 1'b0, 1'b0);
        send_sample(12'd0, 1'b0, 1'b0);
        send_sample(12'd0, 1'b0, 1'b0);
        send_sample(12'd3, 1'b0, 1'b0);
        chk("trunc_vld", out_valid, 1);
        chk("trunc_dat", out_data, 0);
        exp_q.push_back(12'd0);
        drain(1);
        chk("empty_again", level, 0);

        // Fill to 16, then a 17th window is dropped
        for (int i = 0; i < 16; i++) push_window(12'(10 + i), 1'b0, 1'b0);
        chk("full_level", level, 16);
        chk("full_no_ovf", overflow, 0);
        push_window(12'd26, 1'b0, 1'b0);
        chk("ovf_level", level, 16);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", out_data, 10);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        chk("ovf_clear", overflow, 0);
        push_window(12'd27, 1'b0, 1'b1);
        chk("ovf_drop_wins", overflow, 1);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        chk("ovf_clear2", overflow, 0);

        // Push into a full FIFO while popping: both happen
        push_window(12'd99, 1'b1, 1'b0);
        chk("fullpop_level", level, 16);
        chk("fullpop_ovf", overflow, 0);
        chk("fullpop_head", out_data, 11);
        for (int i = 1; i < 16; i++) exp_q.push_back(12'(10 + i));
        exp_q.push_back(12'd99);
        drain(16);
        chk("fullpop_empty", level, 0);

        // Reset mid-window discards the partial sum
        send_sample(12'd500, 1'b0, 1'b0);
        send_sample(12'd500, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        push_window(12'd8, 1'b0, 1'b0);
        chk("midrst_level", level, 1);
        chk("midrst_dat", out_data, 8);
        exp_q.push_back(12'd8);
        drain(1);

        // 40 windows with random backpressure
        exp_q.delete();
        sent = 0;
        sub = 0;
        got = 0;
        stalled = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 2000 && got < 40; cyc++) begin
            vv = 12'(((sent * 37) + 5) & 'h7FF);
            if (sent < 40) begin
                in_valid = 1'b1;
                in_data  = (sub < 2) ? vv : vv + 12'd1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = 1'($urandom_range(0, 1));
            chk("bp_vld", out_valid, exp_q.size() != 0);
            if (stalled) chk("bp_stable", out_data, held);
            if (out_valid && out_ready && exp_q.size() != 0) begin
                chk("bp_dat", out_data, exp_q.pop_front());
                got++;
            end
            if (sent < 40 && sub == 3) exp_q.push_back(vv);
            stalled = out_valid && !out_ready;
            held    = out_data;
            if (sent < 40) begin
                if (sub == 3) begin
                    sub = 0;
                    sent++;
                end else begin
                    sub++;
                end
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("bp_count", got, 40);
        chk("bp_no_ovf", overflow, 0);
        chk("bp_level", level, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sample_fifo.md
SAMPLE_FIFO -- requirements
Module: sample_fifo

Interface
REQ-001 SHALL provide parameter WIDTH, default 12, ADC sample width in bits.
REQ-002 SHALL provide parameter DEPTH_LOG2, default 4, FIFO depth of 2^DEPTH_LOG2 words (16).
REQ-003 SHALL provide parameter AVG_LOG2, default 2, averaging window of 2^AVG_LOG2 samples; 0 = pass-through.
REQ-004 SHALL have port clk, input, 1, single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_data, input, WIDTH, unsigned sample from the ADC serial interface.
REQ-007 SHALL have port in_valid, input, 1, one-cycle strobe marking in_data as a new sample.
REQ-008 SHALL have port out_data, output, WIDTH, averaged sample at FIFO head.
REQ-009 SHALL have port out_valid, output, 1, FIFO non-empty, out_data valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts head word.
REQ-011 SHALL have port level, output, DEPTH_LOG2+1, count of words held.
REQ-012 SHALL have port overflow, output, 1, sticky flag: an averaged word was dropped.
REQ-013 SHALL have port clear_ovf, input, 1, synchronous clear of overflow.

Function
REQ-014 SHALL accumulate in_data on each in_valid edge into a (WIDTH+AVG_LOG2)-bit unsigned accumulator with no overflow possible.
REQ-015 SHALL keep a sample counter 0..2^AVG_LOG2-1 that increments per in_valid and wraps to 0.
REQ-016 SHALL, on the in_valid edge where the counter equals 2^AVG_LOG2-1, form (acc + in_data) >> AVG_LOG2 (truncate, no rounding), push it to the FIFO, and reload acc to 0.
REQ-017 SHALL ignore in_data while in_valid is low; no implied hold or repeat.
REQ-018 SHALL be first-word-fall-through: a word pushed at edge k makes out_valid=1 and out_data=that word immediately after edge k when the FIFO was empty.
REQ-019 SHALL pop the head on any edge where out_valid and out_ready are both 1; out_ready with out_valid=0 has no effect.
REQ-020 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, on simultaneous push and pop, complete both; level unchanged; allowed even when full (no overflow).
REQ-022 SHALL, on push while full with no pop, drop the new word, leave contents and level unchanged, and set overflow.
REQ-023 SHALL clear overflow on clear_ovf; a drop in the same cycle wins (overflow stays 1).
REQ-024 SHALL implement read/write pointers of DEPTH_LOG2 bits that wrap modulo depth; level ranges 0..2^DEPTH_LOG2.
REQ-025 SHALL, with AVG_LOG2=0, push every valid sample unmodified.

Reset
REQ-026 SHALL on rst_n low asynchronously clear acc, sample counter, pointers, level=0, out_valid=0, overflow=0, out_data=0.
REQ-027 SHALL discard a partially accumulated window and all FIFO contents on reset mid-operation; first window after release starts at counter 0.
REQ-028 SHALL ignore in_valid and out_ready while rst_n is low.

Verification
REQ-029 Averaging: AVG_LOG2=2, samples 100,101,102,103 with out_ready=0 -> one word 101 (406>>2), level=1, out_valid=1 after 4th strobe edge.
REQ-030 Full-scale: four samples 0xFFF -> out_data 0xFFF; samples 0,0,0,3 -> out_data 0 (truncation).
REQ-031 Overflow: out_ready=0, 17 windows pushed -> level=16, overflow=1, head = first window value; clear_ovf pulse -> overflow=0.
REQ-032 Full with pop: level=16, out_ready=1 on the cycle of a 17th push -> level stays 16, overflow=0, tail holds new word.
REQ-033 Reset mid-window: 2 samples of 500, rst_n pulse, then 4 samples of 8 -> single word 8, no contribution from 500.
REQ-034 Backpressure/wrap: 40 windows with random out_ready -> output sequence equals pushed sequence in order, out_data stable while stalled.
